// File: rtl/apb_initiator.sv
// APB4 requester: converts a valid/ready request into a single APB transfer and
// returns a held response carrying read data, the slave error and a watchdog flag.
module apb_initiator #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned TO_W    = 8
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [DATA_W/8-1:0]   req_strb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_W-1:0]     PADDR,
  output logic [DATA_W-1:0]     PWDATA,
  output logic [DATA_W/8-1:0]   PSTRB,
  input  logic                  PREADY,
  input  logic                  PSLVERR,
  input  logic [DATA_W-1:0]     PRDATA
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_RESP
  } state_t;

  // Abort once the wait counter would reach TIMEOUT, i.e. on the TIMEOUT-th stalled ACCESS cycle.
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  state_t          state;
  logic [TO_W-1:0] wait_cnt;

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state       <= S_IDLE;
      wait_cnt    <= '0;
      req_ready   <= 1'b1;
      PSEL        <= 1'b0;
      PENABLE     <= 1'b0;
      PWRITE      <= 1'b0;
      PADDR       <= '0;
      PWDATA      <= '0;
      PSTRB       <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            state     <= S_SETUP;
            req_ready <= 1'b0;
            wait_cnt  <= '0;
            PSEL      <= 1'b1;
            PENABLE   <= 1'b0;
            PWRITE    <= req_write;
            PADDR     <= req_addr;
            PWDATA    <= req_write ? req_wdata : '0;
            PSTRB     <= req_write ? req_strb  : '0;
          end
        end
        S_SETUP: begin
          state   <= S_ACCESS;
          PENABLE <= 1'b1;
        end
        S_ACCESS: begin
          if (PREADY) begin
            state       <= S_RESP;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_err     <= PSLVERR;
            rsp_timeout <= 1'b0;
            rsp_rdata   <= (!PWRITE && !PSLVERR) ? PRDATA : '0;
          end else if (wait_cnt == TO_LAST) begin
            state       <= S_RESP;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
            rsp_rdata   <= '0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            state     <= S_IDLE;
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
